// File: rtl/cpu_regfile_pkg.sv
`default_nettype none
// ============================================================================
// cpu_regfile_pkg : shared types and default sizes for the register-file write port
// Rev 1.0
// ============================================================================
package cpu_regfile_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  localparam int DEF_NUM_REQ  = 2;
  localparam int DEF_NUM_REGS = 8;
  localparam int DEF_ADDR_W   = 3;
  localparam int DEF_DATA_W   = 16;

  // Index width that stays legal for a single-entry selector.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_write_ctrl_if.sv
`default_nettype none
// ============================================================================
// regfile_write_ctrl_if : requester/clear handshake and register-cell strobe bus
// Rev 1.0
// ============================================================================
interface regfile_write_ctrl_if #(
  parameter int NUM_REQ  = 2,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3,
  parameter int DATA_W   = 16
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      clear_start;
  logic                      clear_busy;
  logic [NUM_REGS-1:0]       reg_load;
  logic [DATA_W-1:0]         reg_data;
  logic                      err_addr;

  modport master (
    output req_valid, req_addr, req_data, clear_start,
    input  req_ready, clear_busy, reg_load, reg_data, err_addr
  );

  modport slave (
    input  req_valid, req_addr, req_data, clear_start,
    output req_ready, clear_busy, reg_load, reg_data, err_addr
  );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter : round-robin one-hot selector starting the search at ptr_i
// Rev 1.0
// ============================================================================
module rr_arbiter
  import cpu_regfile_pkg::*;
#(
  parameter int N     = DEF_NUM_REQ,
  parameter int PTR_W = idx_w(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic             any_o,
  output logic [PTR_W-1:0] next_ptr_o
);

  // Outer loop walks priority order from the pointer; the inner loop finds the
  // requester at that position so every index stays a loop constant.
  always_comb begin
    gnt_o      = '0;
    any_o      = 1'b0;
    next_ptr_o = ptr_i;
    for (int off = 0; off < N; off++) begin
      for (int i = 0; i < N; i++) begin
        if (!any_o && req_i[i] &&
            ((int'(ptr_i) + off == i) || (int'(ptr_i) + off == i + N))) begin
          any_o      = 1'b1;
          gnt_o[i]   = 1'b1;
          next_ptr_o = (i == N - 1) ? '0 : PTR_W'(i + 1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_write_ctrl.sv
`default_nettype none
// ============================================================================
// regfile_write_ctrl : arbitrated write port and sequenced bulk clear for a
//                      latch-based register file with registered one-hot loads
// Rev 1.0
// ============================================================================
module regfile_write_ctrl
  import cpu_regfile_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_write_ctrl_if.slave  bus
);

  localparam int PTR_W = idx_w(NUM_REQ);

  state_e              state_q;
  logic [PTR_W-1:0]    ptr_q;
  logic [PTR_W-1:0]    ptr_d;
  logic [ADDR_W-1:0]   cnt_q;
  logic [ADDR_W-1:0]   cnt_d;
  logic [NUM_REGS-1:0] load_q;
  logic [DATA_W-1:0]   data_q;
  logic                err_q;

  logic [NUM_REQ-1:0]  gnt;
  logic                gnt_any;
  logic                grant_en;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;
  logic                addr_ok;
  logic [NUM_REGS-1:0] wr_onehot;
  logic [NUM_REGS-1:0] clr_onehot;

  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req_i      (bus.req_valid),
    .ptr_i      (ptr_q),
    .gnt_o      (gnt),
    .any_o      (gnt_any),
    .next_ptr_o (ptr_d)
  );

  // A pending clear_start blocks grants in the same cycle.
  assign grant_en      = (state_q == IDLE) && !bus.clear_start;
  assign bus.req_ready = grant_en ? gnt : '0;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_addr = sel_addr | bus.req_addr[i*ADDR_W +: ADDR_W];
        sel_data = sel_data | bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign addr_ok = int'(sel_addr) < NUM_REGS;
  // Index of the clear strobe to register next: 0 on entry, k+1 while clearing.
  assign cnt_d   = (state_q == CLEAR) ? cnt_q + 1'b1 : '0;

  always_comb begin
    wr_onehot  = '0;
    clr_onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_onehot[i]  = (sel_addr == ADDR_W'(i));
      clr_onehot[i] = (cnt_d == ADDR_W'(i));
    end
  end

  // cnt_q names the clear strobe currently visible on reg_load while in CLEAR.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      load_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      load_q <= '0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.clear_start) begin
            state_q <= CLEAR;
            cnt_q   <= cnt_d;
            load_q  <= clr_onehot;
            data_q  <= '0;
          end else if (gnt_any) begin
            ptr_q <= ptr_d;
            if (addr_ok) begin
              load_q <= wr_onehot;
              data_q <= sel_data;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        CLEAR: begin
          if (cnt_q == ADDR_W'(NUM_REGS - 1)) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q  <= cnt_d;
            load_q <= clr_onehot;
            data_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.reg_load   = load_q;
  assign bus.reg_data   = data_q;
  assign bus.err_addr   = err_q;
  assign bus.clear_busy = (state_q == CLEAR);

  a_load_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(load_q));

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_ctrl.sv
`default_nettype none
// ============================================================================
// tb_regfile_write_ctrl : directed scenarios plus randomized run against a
//                         behavioural register-file model
// ============================================================================
module tb_regfile_write_ctrl;

  localparam int NREQ  = 2;
  localparam int NREGS = 8;
  localparam int NR6   = 6;
  localparam int AW    = 3;
  localparam int DW    = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  regfile_write_ctrl_if #(.NUM_REQ(NREQ), .NUM_REGS(NREGS), .ADDR_W(AW), .DATA_W(DW)) b8();
  regfile_write_ctrl_if #(.NUM_REQ(NREQ), .NUM_REGS(NR6),   .ADDR_W(AW), .DATA_W(DW)) b6();

  regfile_write_ctrl #(.NUM_REQ(NREQ), .NUM_REGS(NREGS), .ADDR_W(AW), .DATA_W(DW)) u8 (
    .clk(clk), .reset(reset), .bus(b8));
  regfile_write_ctrl #(.NUM_REQ(NREQ), .NUM_REGS(NR6), .ADDR_W(AW), .DATA_W(DW)) u6 (
    .clk(clk), .reset(reset), .bus(b6));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input int a0, input int a1,
                       input logic [15:0] d0, input logic [15:0] d1, input logic cs);
    b8.req_valid   = v;
    b8.req_addr    = {AW'(a1), AW'(a0)};
    b8.req_data    = {d1, d0};
    b8.clear_start = cs;
    #1;
  endtask

  task automatic drive6(input logic [1:0] v, input int a0, input int a1,
                        input logic [15:0] d0, input logic [15:0] d1);
    b6.req_valid   = v;
    b6.req_addr    = {AW'(a1), AW'(a0)};
    b6.req_data    = {d1, d0};
    b6.clear_start = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(2'b00, 0, 0, 16'h0, 16'h0, 1'b0);
    drive6(2'b00, 0, 0, 16'h0, 16'h0);
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({b8.clear_busy, b8.err_addr, b8.reg_load, b8.reg_data} !== 26'h0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b err=%b load=%h data=%h, expected all zero",
               b8.clear_busy, b8.err_addr, b8.reg_load, b8.reg_data);
    end
    checks++;
    if ({b6.clear_busy, b6.err_addr, b6.reg_load, b6.reg_data} !== 24'h0) begin
      errors++;
      $display("FAIL reset_outputs6: got busy=%b err=%b load=%h data=%h, expected all zero",
               b6.clear_busy, b6.err_addr, b6.reg_load, b6.reg_data);
    end
  endtask

  task automatic test_single_write();
    do_reset();
    drive(2'b01, 3, 0, 16'hBEEF, 16'h0, 1'b0);
    checks++;
    if (b8.req_ready !== 2'b01) begin
      errors++; $display("FAIL single_ready: got %b expected 01", b8.req_ready);
    end
    step();
    drive(2'b00, 0, 0, 16'h0, 16'h0, 1'b0);
    checks++;
    if ({b8.reg_load, b8.reg_data, b8.err_addr} !== {8'h08, 16'hBEEF, 1'b0}) begin
      errors++;
      $display("FAIL single_strobe: got load=%h data=%h err=%b expected 08 beef 0",
               b8.reg_load, b8.reg_data, b8.err_addr);
    end
    step();
    checks++;
    if ({b8.reg_load, b8.reg_data} !== {8'h00, 16'hBEEF}) begin
      errors++;
      $display("FAIL single_after: got load=%h data=%h expected 00 beef", b8.reg_load, b8.reg_data);
    end
  endtask

  task automatic test_contention();
    logic [1:0]  eg;
    logic [7:0]  el;
    logic [15:0] ed;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      drive(2'b11, 1, 2, 16'hA000 + 16'(c), 16'hB000 + 16'(c), 1'b0);
      eg = (c % 2 == 0) ? 2'b01 : 2'b10;
      el = (c % 2 == 0) ? 8'h02 : 8'h04;
      ed = (c % 2 == 0) ? 16'hA000 + 16'(c) : 16'hB000 + 16'(c);
      checks++;
      if (b8.req_ready !== eg) begin
        errors++; $display("FAIL contention_ready[%0d]: got %b expected %b", c, b8.req_ready, eg);
      end
      step();
      checks++;
      if ({b8.reg_load, b8.reg_data} !== {el, ed}) begin
        errors++;
        $display("FAIL contention_strobe[%0d]: got load=%h data=%h expected %h %h",
                 c, b8.reg_load, b8.reg_data, el, ed);
      end
    end
    drive(2'b00, 0, 0, 16'h0, 16'h0, 1'b0);
    step();
    checks++;
    if (b8.reg_load !== 8'h00) begin
      errors++; $display("FAIL contention_idle: got load=%h expected 00", b8.reg_load);
    end
  endtask

  task automatic test_bad_addr();
    do_reset();
    drive6(2'b01, 6, 0, 16'h5555, 16'h0);
    checks++;
    if (b6.req_ready !== 2'b01) begin
      errors++; $display("FAIL bad_ready0: got %b expected 01", b6.req_ready);
    end
    step();
    checks++;
    if ({b6.reg_load, b6.err_addr, b6.reg_data} !== {6'h00, 1'b1, 16'h0}) begin
      errors++;
      $display("FAIL bad_strobe0: got load=%h err=%b data=%h expected 00 1 0000",
               b6.reg_load, b6.err_addr, b6.reg_data);
    end
    drive6(2'b11, 2, 7, 16'h1111, 16'h7777);
    checks++;
    if (b6.req_ready !== 2'b10) begin
      errors++; $display("FAIL bad_ptr_advance: got %b expected 10", b6.req_ready);
    end
    step();
    checks++;
    if ({b6.reg_load, b6.err_addr} !== {6'h00, 1'b1}) begin
      errors++; $display("FAIL bad_strobe1: got load=%h err=%b expected 00 1", b6.reg_load, b6.err_addr);
    end
    drive6(2'b11, 2, 5, 16'h2222, 16'h3333);
    checks++;
    if (b6.req_ready !== 2'b01) begin
      errors++; $display("FAIL bad_ready2: got %b expected 01", b6.req_ready);
    end
    step();
    drive6(2'b00, 0, 0, 16'h0, 16'h0);
    checks++;
    if ({b6.reg_load, b6.err_addr, b6.reg_data} !== {6'h04, 1'b0, 16'h2222}) begin
      errors++;
      $display("FAIL bad_good_write: got load=%h err=%b data=%h expected 04 0 2222",
               b6.reg_load, b6.err_addr, b6.reg_data);
    end
    step();
    checks++;
    if ({b6.reg_load, b6.err_addr} !== {6'h00, 1'b0}) begin
      errors++; $display("FAIL bad_quiet: got load=%h err=%b expected 00 0", b6.reg_load, b6.err_addr);
    end
  endtask

  task automatic test_clear_vs_request();
    logic [7:0] el;
    do_reset();
    drive(2'b11, 1, 2, 16'h1234, 16'h5678, 1'b1);
    checks++;
    if (b8.req_ready !== 2'b00) begin
      errors++; $display("FAIL clear_start_ready: got %b expected 00", b8.req_ready);
    end
    step();
    for (int k = 0; k < NREGS; k++) begin
      // A second clear_start mid-sequence must not restart the walk.
      drive(2'b11, 1, 2, 16'h1234, 16'h5678, (k == 2));
      el = 8'h01 << k;
      checks++;
      if ({b8.clear_busy, b8.reg_load, b8.reg_data, b8.req_ready} !== {1'b1, el, 16'h0, 2'b00}) begin
        errors++;
        $display("FAIL clear_step[%0d]: got busy=%b load=%h data=%h ready=%b expected 1 %h 0000 00",
                 k, b8.clear_busy, b8.reg_load, b8.reg_data, b8.req_ready, el);
      end
      step();
    end
    drive(2'b11, 1, 2, 16'h1234, 16'h5678, 1'b0);
    checks++;
    if ({b8.clear_busy, b8.reg_load, b8.req_ready} !== {1'b0, 8'h00, 2'b01}) begin
      errors++;
      $display("FAIL clear_done: got busy=%b load=%h ready=%b expected 0 00 01",
               b8.clear_busy, b8.reg_load, b8.req_ready);
    end
    step();
    drive(2'b00, 0, 0, 16'h0, 16'h0, 1'b0);
    checks++;
    if ({b8.reg_load, b8.reg_data} !== {8'h02, 16'h1234}) begin
      errors++;
      $display("FAIL clear_then_write: got load=%h data=%h expected 02 1234", b8.reg_load, b8.reg_data);
    end
  endtask

  task automatic test_write_then_clear();
    do_reset();
    drive(2'b01, 4, 0, 16'hCAFE, 16'h0, 1'b0);
    step();
    drive(2'b11, 1, 2, 16'h1, 16'h2, 1'b1);
    checks++;
    if ({b8.reg_load, b8.reg_data, b8.req_ready} !== {8'h10, 16'hCAFE, 2'b00}) begin
      errors++;
      $display("FAIL wtc_write: got load=%h data=%h ready=%b expected 10 cafe 00",
               b8.reg_load, b8.reg_data, b8.req_ready);
    end
    step();
    drive(2'b00, 0, 0, 16'h0, 16'h0, 1'b0);
    checks++;
    if ({b8.clear_busy, b8.reg_load, b8.reg_data} !== {1'b1, 8'h01, 16'h0}) begin
      errors++;
      $display("FAIL wtc_first_clear: got busy=%b load=%h data=%h expected 1 01 0000",
               b8.clear_busy, b8.reg_load, b8.reg_data);
    end
    for (int i = 0; i < NREGS; i++) step();
    checks++;
    if ({b8.clear_busy, b8.reg_load} !== {1'b0, 8'h00}) begin
      errors++; $display("FAIL wtc_end: got busy=%b load=%h expected 0 00", b8.clear_busy, b8.reg_load);
    end
  endtask

  task automatic test_reset_mid_clear();
    do_reset();
    drive(2'b00, 0, 0, 16'h0, 16'h0, 1'b1);
    step();
    drive(2'b00, 0, 0, 16'h0, 16'h0, 1'b0);
    step();
    step();
    step();
    checks++;
    if (b8.reg_load !== 8'h08) begin
      errors++; $display("FAIL rmc_step3: got load=%h expected 08", b8.reg_load);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({b8.clear_busy, b8.reg_load, b8.err_addr, b8.reg_data} !== {1'b0, 8'h00, 1'b0, 16'h0}) begin
      errors++;
      $display("FAIL rmc_after_reset: got busy=%b load=%h err=%b data=%h expected 0 00 0 0000",
               b8.clear_busy, b8.reg_load, b8.err_addr, b8.reg_data);
    end
    drive(2'b11, 5, 5, 16'h7777, 16'h8888, 1'b0);
    checks++;
    if (b8.req_ready !== 2'b01) begin
      errors++; $display("FAIL rmc_ptr: got %b expected 01", b8.req_ready);
    end
    drive(2'b01, 5, 0, 16'h7777, 16'h0, 1'b0);
    step();
    drive(2'b00, 0, 0, 16'h0, 16'h0, 1'b0);
    checks++;
    if ({b8.reg_load, b8.reg_data, b8.clear_busy} !== {8'h20, 16'h7777, 1'b0}) begin
      errors++;
      $display("FAIL rmc_write: got load=%h data=%h busy=%b expected 20 7777 0",
               b8.reg_load, b8.reg_data, b8.clear_busy);
    end
  endtask

  // Model: what the register cells should hold, plus the strobe expected next cycle.
  task automatic test_back_to_back();
    logic [15:0] mregs [NREGS];
    logic [15:0] dregs [NREGS];
    int          mptr, clr, nclr, w, addr;
    bit          found, diff;
    logic [7:0]  eload, nload;
    logic [15:0] edata, ndata;
    logic        eerr, nerr, cs;
    logic [1:0]  v, ngnt;
    int          a0, a1;
    logic [15:0] d0, d1;
    do_reset();
    for (int r = 0; r < NREGS; r++) begin
      mregs[r] = '0;
      dregs[r] = '0;
    end
    mptr = 0; clr = -1; eload = '0; edata = '0; eerr = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      checks++;
      if ({b8.clear_busy, b8.err_addr, b8.reg_load, b8.reg_data} !== {(clr >= 0), eerr, eload, edata}) begin
        errors++;
        $display("FAIL stress_out[%0d]: got busy=%b err=%b load=%h data=%h expected %b %b %h %h",
                 n, b8.clear_busy, b8.err_addr, b8.reg_load, b8.reg_data, (clr >= 0), eerr, eload, edata);
      end
      checks++;
      if ($countones(b8.reg_load) > 1) begin
        errors++; $display("FAIL stress_onehot[%0d]: got load=%h expected at most one bit", n, b8.reg_load);
      end
      diff = 1'b0;
      for (int r = 0; r < NREGS; r++) begin
        if (b8.reg_load[r]) dregs[r] = b8.reg_data;
        if (eload[r])       mregs[r] = edata;
        if (dregs[r] !== mregs[r]) diff = 1'b1;
      end
      checks++;
      if (diff) begin
        errors++; $display("FAIL stress_regfile[%0d]: got r0=%h expected r0=%h (some entry differs)",
                           n, dregs[0], mregs[0]);
      end
      v  = 2'($urandom_range(0, 3));
      a0 = $urandom_range(0, NREGS - 1);
      a1 = $urandom_range(0, NREGS - 1);
      d0 = 16'($urandom);
      d1 = 16'($urandom);
      cs = ($urandom_range(0, 99) == 0);
      drive(v, a0, a1, d0, d1, cs);
      nload = '0; nerr = 1'b0; ndata = edata; ngnt = '0; found = 1'b0;
      if (clr >= 0) begin
        nclr = (clr + 1 < NREGS) ? clr + 1 : -1;
        if (nclr >= 0) begin nload = 8'h01 << nclr; ndata = '0; end
      end else if (cs) begin
        nclr = 0; nload = 8'h01; ndata = '0;
      end else begin
        nclr = -1;
        for (int off = 0; off < NREQ; off++) begin
          w = (mptr + off) % NREQ;
          if (!found && v[w]) begin
            found = 1'b1;
            ngnt[w] = 1'b1;
            mptr = (w + 1) % NREQ;
            addr = (w == 1) ? a1 : a0;
            if (addr < NREGS) begin
              nload = 8'h01 << addr;
              ndata = (w == 1) ? d1 : d0;
            end else begin
              nerr = 1'b1;
            end
          end
        end
      end
      checks++;
      if (b8.req_ready !== ngnt) begin
        errors++; $display("FAIL stress_ready[%0d]: got %b expected %b", n, b8.req_ready, ngnt);
      end
      step();
      clr = nclr; eload = nload; edata = ndata; eerr = nerr;
      if (errors > 40) break;
    end
    drive(2'b00, 0, 0, 16'h0, 16'h0, 1'b0);
  endtask

  initial begin
    b8.req_valid = '0; b8.req_addr = '0; b8.req_data = '0; b8.clear_start = 1'b0;
    b6.req_valid = '0; b6.req_addr = '0; b6.req_data = '0; b6.clear_start = 1'b0;
    test_reset();
    test_single_write();
    test_contention();
    test_bad_addr();
    test_clear_vs_request();
    test_write_then_clear();
    test_reset_mid_clear();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation still running at %0t, expected completion earlier", $time);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
